// File: rtl/ram_rw_arbiter_if.sv
// Requester handshakes and RAM read/write port bundled for the two-port arbiter.
// "slave" is the arbiter's view; "master" is the requesters plus the RAM.
interface ram_rw_arbiter_if;
   logic        req0_valid;
   logic        req0_write;
   logic [63:0] req0_addr;
   logic [63:0] req0_wdata;
   logic        req0_ready;
   logic        rsp0_valid;
   logic [63:0] rsp0_rdata;
   logic        rsp0_error;

   logic        req1_valid;
   logic        req1_write;
   logic [63:0] req1_addr;
   logic [63:0] req1_wdata;
   logic        req1_ready;
   logic        rsp1_valid;
   logic [63:0] rsp1_rdata;
   logic        rsp1_error;

   logic [63:0] ram_addr;
   logic [63:0] ram_data_in;
   logic        ram_write_en;
   logic [63:0] ram_data_out;
   logic        ram_error;

   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata, rsp0_error,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_rdata, rsp1_error,
      output ram_addr, ram_data_in, ram_write_en,
      input  ram_data_out, ram_error
   );

   modport master (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_error,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_error,
      input  ram_addr, ram_data_in, ram_write_en,
      output ram_data_out, ram_error
   );
endinterface

// File: rtl/ram_rw_arbiter.sv
// Round-robin arbiter sharing one 64-bit RAM read/write port between two requesters,
// one access in flight at a time; misaligned accesses are answered with an error.
module ram_rw_arbiter #(
   parameter int RAM_LAT   = 1,
   parameter bit ALIGN_CHK = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   ram_rw_arbiter_if.slave io_bus
);
   localparam int CW = $clog2(RAM_LAT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_last_grant;
   logic          r_port;
   logic          r_write;
   logic          r_misalign;
   logic          r_ram_we;
   logic [63:0]   r_ram_addr;
   logic [63:0]   r_ram_din;
   logic [CW-1:0] r_lat_cnt;
   logic          r_rsp0_valid;
   logic          r_rsp1_valid;
   logic          r_rsp0_error;
   logic          r_rsp1_error;
   logic [63:0]   r_rsp0_rdata;
   logic [63:0]   r_rsp1_rdata;

   logic          w_any;
   logic          w_winner;
   logic          w_accept;
   logic          w_sel_write;
   logic          w_sel_misalign;
   logic          w_done;
   logic          w_rsp_error;
   logic [63:0]   w_sel_addr;
   logic [63:0]   w_sel_wdata;
   logic [63:0]   w_rsp_rdata;

   // On a tie the port that did not win last time is granted.
   always_comb begin
      w_any          = io_bus.req0_valid | io_bus.req1_valid;
      w_winner       = (io_bus.req0_valid && io_bus.req1_valid) ? ~r_last_grant : io_bus.req1_valid;
      w_accept       = (r_state == IDLE) && !reset && w_any;
      w_sel_write    = w_winner ? io_bus.req1_write : io_bus.req0_write;
      w_sel_addr     = w_winner ? io_bus.req1_addr  : io_bus.req0_addr;
      w_sel_wdata    = w_winner ? io_bus.req1_wdata : io_bus.req0_wdata;
      w_sel_misalign = ALIGN_CHK && (w_sel_addr[2:0] != 3'b000);
      w_done         = (r_state == ACCESS) && (r_lat_cnt == CW'(1));
      w_rsp_error    = io_bus.ram_error | r_misalign;
      w_rsp_rdata    = (r_write || w_rsp_error) ? 64'd0 : io_bus.ram_data_out;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = ACCESS;
         ACCESS:  if (w_done)   w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_port       <= 1'b0;
         r_write      <= 1'b0;
         r_misalign   <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= 64'd0;
         r_ram_din    <= 64'd0;
         r_lat_cnt    <= '0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_error <= 1'b0;
         r_rsp1_error <= 1'b0;
         r_rsp0_rdata <= 64'd0;
         r_rsp1_rdata <= 64'd0;
      end else begin
         r_state      <= w_state_next;
         r_ram_we     <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         if (w_accept) begin
            r_port       <= w_winner;
            r_last_grant <= w_winner;
            r_write      <= w_sel_write;
            r_misalign   <= w_sel_misalign;
            r_ram_addr   <= w_sel_addr;
            r_ram_din    <= w_sel_wdata;
            r_ram_we     <= w_sel_write && !w_sel_misalign;
            r_lat_cnt    <= CW'(RAM_LAT);
         end
         if (r_state == ACCESS) begin
            r_lat_cnt <= r_lat_cnt - CW'(1);
         end
         // Only the sample taken on the last ACCESS cycle reaches the requester.
         if (w_done && !r_port) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_rdata <= w_rsp_rdata;
            r_rsp0_error <= w_rsp_error;
         end
         if (w_done && r_port) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_rdata <= w_rsp_rdata;
            r_rsp1_error <= w_rsp_error;
         end
      end
   end

   assign io_bus.req0_ready   = w_accept && !w_winner;
   assign io_bus.req1_ready   = w_accept && w_winner;
   assign io_bus.rsp0_valid   = r_rsp0_valid;
   assign io_bus.rsp0_rdata   = r_rsp0_rdata;
   assign io_bus.rsp0_error   = r_rsp0_error;
   assign io_bus.rsp1_valid   = r_rsp1_valid;
   assign io_bus.rsp1_rdata   = r_rsp1_rdata;
   assign io_bus.rsp1_error   = r_rsp1_error;
   assign io_bus.ram_addr     = r_ram_addr;
   assign io_bus.ram_data_in  = r_ram_din;
   assign io_bus.ram_write_en = r_ram_we;
endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Bench for ram_rw_arbiter: small RAM, transaction-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_ram_rw_arbiter;
   localparam int          RAM_WORDS = 64;
   localparam logic [63:0] RAM_BYTES = 64'd512;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   we_cnt  = 0;
   int   rsp_cnt = 0;

   ram_rw_arbiter_if bus();

   ram_rw_arbiter #(.RAM_LAT(1), .ALIGN_CHK(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .io_bus(bus)
   );

   always #5 clk = ~clk;

   logic [63:0] ram_mem   [RAM_WORDS];
   logic [63:0] model_mem [RAM_WORDS];

   initial begin
      for (int i = 0; i < RAM_WORDS; i++) begin
         ram_mem[i]   = 64'hA5A5_0000_0000_0000 | 64'(i);
         model_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      end
   end

   // RAM: read data valid within the access cycle; out-of-range addresses flag an error.
   always_comb begin
      bus.ram_error    = (bus.ram_addr >= RAM_BYTES);
      bus.ram_data_out = bus.ram_error ? 64'hBADB_AD00_BADB_AD00 : ram_mem[bus.ram_addr[8:3]];
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.ram_write_en) begin
         we_cnt = we_cnt + 1;
         if (bus.ram_addr < RAM_BYTES) ram_mem[bus.ram_addr[8:3]] = bus.ram_data_in;
      end
      if (bus.rsp0_valid || bus.rsp1_valid) rsp_cnt = rsp_cnt + 1;
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void timeout(string name);
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
   endfunction

   // Reference model: one access at a time, response one cycle after the access cycle.
   bit          m_last_grant = 1'b1;
   int          m_idle_at    = 0;
   bit          m_pend       = 1'b0;
   int          m_acc        = 0;
   bit          m_port       = 1'b0;
   bit          m_write      = 1'b0;
   logic [63:0] m_addr       = 64'd0;
   logic [63:0] m_wdata      = 64'd0;
   logic [63:0] m_rdata [2]  = '{64'd0, 64'd0};
   bit          m_err   [2]  = '{1'b0, 1'b0};
   int          grant_log [$];

   always @(negedge clk) begin : compare
      bit          er0, er1, exp_we, pend_due, e_err;
      logic [63:0] e_rd;
      if (reset) begin
         chk("rst_ready0", bus.req0_ready, 0);
         chk("rst_ready1", bus.req1_ready, 0);
         chk("rst_rsp0_valid", bus.rsp0_valid, 0);
         chk("rst_rsp1_valid", bus.rsp1_valid, 0);
         chk("rst_ram_we", bus.ram_write_en, 0);
         chk("rst_ram_addr", bus.ram_addr, 0);
         chk("rst_rsp0_rdata", bus.rsp0_rdata, 0);
         chk("rst_rsp1_rdata", bus.rsp1_rdata, 0);
         m_last_grant = 1'b1;
         m_idle_at    = 0;
         m_pend       = 1'b0;
         m_rdata[0]   = 64'd0;
         m_rdata[1]   = 64'd0;
         m_err[0]     = 1'b0;
         m_err[1]     = 1'b0;
      end else begin
         er0 = (cyc >= m_idle_at) && bus.req0_valid && (!bus.req1_valid || m_last_grant);
         er1 = (cyc >= m_idle_at) && bus.req1_valid && (!bus.req0_valid || !m_last_grant);
         chk("ready0", bus.req0_ready, er0);
         chk("ready1", bus.req1_ready, er1);

         exp_we = m_pend && (cyc == m_acc) && m_write && (m_addr[2:0] == 3'b000);
         chk("ram_we", bus.ram_write_en, exp_we);
         if (m_pend && cyc == m_acc) begin
            chk("ram_addr", bus.ram_addr, m_addr);
            if (exp_we) chk("ram_wdata", bus.ram_data_in, m_wdata);
         end

         pend_due = m_pend && (cyc == m_acc + 1);
         if (pend_due) begin
            e_err = (m_addr[2:0] != 3'b000) || (m_addr >= RAM_BYTES);
            e_rd  = (m_write || e_err) ? 64'd0 : model_mem[m_addr[8:3]];
            if (m_write && !e_err) model_mem[m_addr[8:3]] = m_wdata;
            m_rdata[m_port] = e_rd;
            m_err[m_port]   = e_err;
            m_pend          = 1'b0;
         end
         chk("rsp0_valid", bus.rsp0_valid, pend_due && !m_port);
         chk("rsp1_valid", bus.rsp1_valid, pend_due && m_port);
         chk("rsp0_rdata", bus.rsp0_rdata, m_rdata[0]);
         chk("rsp0_error", bus.rsp0_error, m_err[0]);
         chk("rsp1_rdata", bus.rsp1_rdata, m_rdata[1]);
         chk("rsp1_error", bus.rsp1_error, m_err[1]);

         if (er0 || er1) begin
            m_pend       = 1'b1;
            m_port       = er1;
            m_write      = er1 ? bus.req1_write : bus.req0_write;
            m_addr       = er1 ? bus.req1_addr  : bus.req0_addr;
            m_wdata      = er1 ? bus.req1_wdata : bus.req0_wdata;
            m_acc        = cyc + 1;
            m_idle_at    = cyc + 3;
            m_last_grant = er1;
            grant_log.push_back(int'(er1));
         end
      end
   end

   task automatic issue(input int port, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, output int acc_cyc);
      bit got = 1'b0;
      @(posedge clk); #1;
      if (port == 0) begin
         bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata; bus.req1_valid = 1'b1;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         got = (port == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!got) timeout("issue_ready");
      @(posedge clk); #1;
      acc_cyc = cyc;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      $display("req port=%0d write=%0d addr=%h wdata=%h accepted at cycle %0d", port, wr, addr, wdata, acc_cyc);
   endtask

   task automatic wait_rsp(input int port, output logic [63:0] rd, output bit er, output int rsp_cyc);
      bit got = 1'b0;
      rd = 64'hx; er = 1'b0; rsp_cyc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         got = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      end
      if (!got) begin
         timeout("wait_rsp");
      end else begin
         rd      = (port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
         er      = (port == 0) ? bus.rsp0_error : bus.rsp1_error;
         rsp_cyc = cyc;
         $display("rsp port=%0d rdata=%h error=%0d at cycle %0d", port, rd, er, rsp_cyc);
      end
   endtask

   task automatic wait_grants(input int n);
      bit done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk); #1;
         done = (grant_log.size() >= n);
      end
      if (!done) timeout("wait_grants");
   endtask

   initial begin : stim
      int          acc, rc, w0, r0;
      logic [63:0] rd;
      bit          er;

      bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 64'd0; bus.req0_wdata = 64'd0;
      bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 64'd0; bus.req1_wdata = 64'd0;

      repeat (2) @(negedge clk);
      chk("reset_ready0", bus.req0_ready, 0);
      chk("reset_rsp0_valid", bus.rsp0_valid, 0);
      @(posedge clk); #2 reset = 1'b0;

      // 1: aligned store
      w0 = we_cnt;
      issue(0, 1'b1, 64'h100, 64'hDEAD_BEEF, acc);
      wait_rsp(0, rd, er, rc);
      chk("t1_latency", 64'(rc + 1 - acc), 2);
      chk("t1_rdata", rd, 64'd0);
      chk("t1_error", er, 0);
      chk("t1_we_pulses", 64'(we_cnt - w0), 1);

      // 2: load back
      issue(0, 1'b0, 64'h100, 64'd0, acc);
      wait_rsp(0, rd, er, rc);
      chk("t2_rdata", rd, 64'hDEAD_BEEF);
      chk("t2_error", er, 0);

      // 3: both ports held valid, fresh fairness state
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      grant_log.delete();
      @(posedge clk); #1;
      bus.req0_write = 1'b0; bus.req0_addr = 64'h100; bus.req0_valid = 1'b1;
      bus.req1_write = 1'b0; bus.req1_addr = 64'h108; bus.req1_valid = 1'b1;
      wait_grants(4);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (4) @(posedge clk);
      chk("t3_grant_count", 64'(grant_log.size()), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
         chk("t3_grant_order", 64'(grant_log[i]), 64'(i % 2));
         $display("grant %0d -> port %0d", i, grant_log[i]);
      end

      // 4: misaligned store on port 1, memory untouched
      w0 = we_cnt;
      issue(1, 1'b1, 64'h103, 64'h5555_5555, acc);
      wait_rsp(1, rd, er, rc);
      chk("t4_error", er, 1);
      chk("t4_rdata", rd, 64'd0);
      chk("t4_we_pulses", 64'(we_cnt - w0), 0);
      issue(0, 1'b0, 64'h100, 64'd0, acc);
      wait_rsp(0, rd, er, rc);
      chk("t4_mem_kept", rd, 64'hDEAD_BEEF);

      // 5: out-of-range load
      issue(0, 1'b0, 64'h1000, 64'd0, acc);
      wait_rsp(0, rd, er, rc);
      chk("t5_error", er, 1);
      chk("t5_rdata", rd, 64'd0);

      // 6: reset during the ACCESS cycle of a store
      w0 = we_cnt;
      issue(0, 1'b1, 64'h110, 64'h1234_5678, acc);
      reset = 1'b1;
      #1;
      chk("t6_ram_we", bus.ram_write_en, 0);
      chk("t6_ram_addr", bus.ram_addr, 64'd0);
      chk("t6_ram_din", bus.ram_data_in, 64'd0);
      chk("t6_ready0", bus.req0_ready, 0);
      r0 = rsp_cnt;
      @(posedge clk); @(posedge clk); #2 reset = 1'b0;
      repeat (4) @(posedge clk);
      chk("t6_no_rsp", 64'(rsp_cnt - r0), 0);
      chk("t6_no_write", 64'(we_cnt - w0), 0);
      grant_log.delete();
      @(posedge clk); #1;
      bus.req0_write = 1'b0; bus.req0_addr = 64'h110; bus.req0_valid = 1'b1;
      bus.req1_write = 1'b0; bus.req1_addr = 64'h108; bus.req1_valid = 1'b1;
      wait_grants(1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      if (grant_log.size() > 0) chk("t6_tie_winner", 64'(grant_log[0]), 0);
      wait_rsp(0, rd, er, rc);
      chk("t6_mem_kept", rd, 64'hA5A5_0000_0000_0022);
      chk("t6_error", er, 0);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
